// File: rtl/uart_rx_frame_receiver.sv
// UART receiver: 2-FF synchroniser, 3-sample majority vote, 8N1 frames (8E1 when UART_RX_PARITY_EN is defined).
// Emits one-cycle rdata_valid / framing_error / parity_error pulses, all registered.
module uart_rx_frame_receiver #(
   parameter int FMAX_MHz  = 27,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rdata,
   output logic       rdata_valid,
   output logic       framing_error,
   output logic       parity_error
);

   localparam int CLKS_PER_BIT = FMAX_MHz * 1_000_000 / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_S0   = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(HALF_BIT);
   localparam logic [CW-1:0] CNT_MID  = CW'(HALF_BIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_frame_receiver: CLKS_PER_BIT must be at least 4");
   end

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

`ifdef UART_RX_PARITY_EN
   function automatic logic parity_even(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   logic          rx_meta_q, rx_sync_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          smp0_q, smp0_d, smp1_q, smp1_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_q, par_bad_d;
   logic          perr_q, perr_d;
`endif

   logic rx_s, sample_s, at_mid_s, cnt_last_s;

   assign rx_s       = rx_sync_q;
   assign sample_s   = vote3(smp0_q, smp1_q, rx_s);
   assign at_mid_s   = (bit_cnt_q == CNT_MID);
   assign cnt_last_s = (bit_cnt_q == CNT_LAST);

   // Frame sequencing, sampling and output pulse generation.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      rdata_d   = rdata_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      if (bit_cnt_q == CNT_S0) smp0_d = rx_s;
      else                     smp0_d = smp0_q;
      if (bit_cnt_q == CNT_S1) smp1_d = rx_s;
      else                     smp1_d = smp1_q;
      if (cnt_last_s) bit_cnt_d = CNT_ZERO;
      else            bit_cnt_d = bit_cnt_q + CNT_ONE;

      case (state_q)
         ST_IDLE: begin
            // The cycle the low line is first seen is clock 0 of the start bit.
            if (!rx_s) begin
               state_d   = ST_START;
               bit_cnt_d = CNT_ONE;
            end else begin
               bit_cnt_d = CNT_ZERO;
            end
         end
         ST_START: begin
            if (at_mid_s && sample_s) begin
               state_d   = ST_IDLE;
               bit_cnt_d = CNT_ZERO;
            end else if (cnt_last_s) begin
               state_d = ST_DATA;
               idx_d   = 3'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_DATA: begin
            if (at_mid_s) shift_d = {sample_s, shift_q[7:1]};
            else          shift_d = shift_q;
            if (cnt_last_s) begin
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (at_mid_s) par_bad_d = (sample_s != parity_even(shift_q));
            else          par_bad_d = par_bad_q;
            if (cnt_last_s) state_d = ST_STOP;
            else            state_d = state_q;
         end
`endif
         ST_STOP: begin
            // Decide at mid-stop so a back-to-back start edge is not missed.
            if (at_mid_s) begin
               bit_cnt_d = CNT_ZERO;
               if (sample_s) begin
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) begin
                     perr_d = 1'b1;
                  end else begin
                     rdata_d = shift_q;
                     valid_d = 1'b1;
                  end
`else
                  rdata_d = shift_q;
                  valid_d = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_BREAK: begin
            bit_cnt_d = CNT_ZERO;
            if (rx_s) state_d = ST_IDLE;
            else      state_d = state_q;
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = CNT_ZERO;
         end
      endcase
   end

   // Synchroniser and receiver state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= ST_IDLE;
         bit_cnt_q <= CNT_ZERO;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         smp0_q    <= 1'b1;
         smp1_q    <= 1'b1;
         rdata_q   <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         smp0_q    <= smp0_d;
         smp1_q    <= smp1_d;
         rdata_q   <= rdata_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity check result and parity error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
      end
   end
   assign parity_error = perr_q;
`else
   assign parity_error = 1'b0;
`endif

   assign rdata         = rdata_q;
   assign rdata_valid   = valid_q;
   assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Self-checking bench for uart_rx_frame_receiver: directed scenarios plus randomized frames
// checked against a frame-level event queue (expected pulse kind and byte per frame).
module tb_uart_rx_frame_receiver;

   localparam int CLKS = 234;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int EXP_LAT = PAR_EN ? 2225 + CLKS : 2225;

   typedef struct {
      int         kind;   // 0 = valid byte, 1 = framing error, 2 = parity error
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       uart_rx;
   logic [7:0] rdata;
   logic       rdata_valid, framing_error, parity_error;

   ev_t        exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         pulse_cnt = 0;
   int         lat_mark = -1;
   int         lat_seen = -1;
   bit         lat_arm  = 1'b0;
   logic [7:0] last_good = 8'h00;

   uart_rx_frame_receiver dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .uart_rx       (uart_rx),
      .rdata         (rdata),
      .rdata_valid   (rdata_valid),
      .framing_error (framing_error),
      .parity_error  (parity_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Every output pulse is matched against the next expected frame outcome.
   always @(negedge clk) begin : monitor
      int  npulse;
      int  kind;
      ev_t e;
      if (rst_n === 1'b1) begin
         npulse = int'(rdata_valid) + int'(framing_error) + int'(parity_error);
         if (npulse != 0) begin
            pulse_cnt++;
            check("pulse_exclusive", npulse, 1);
            kind = rdata_valid ? 0 : (framing_error ? 1 : 2);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse_kind", kind, 99);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", kind, e.kind);
               if (e.kind == 0) begin
                  check("rdata", rdata, e.data);
                  last_good = e.data;
               end else begin
                  check("rdata_held", rdata, last_good);
               end
            end
            if (rdata_valid && lat_mark >= 0) begin
               lat_seen = cyc - lat_mark - 1;
               lat_mark = -1;
            end
         end
      end
   end

   task automatic send_bit(input logic v);
      uart_rx = v;
      repeat (CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
      ev_t  e;
      logic pbit;
      e.kind = (stop_v == 1'b0) ? 1 : ((PAR_EN && par_flip) ? 2 : 0);
      e.data = b;
      exp_q.push_back(e);
      if (lat_arm) begin
         lat_mark = cyc;
         lat_arm  = 1'b0;
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (PAR_EN) begin
         pbit = (($countones(b) % 2) == 1) ? 1'b1 : 1'b0;
         send_bit(pbit ^ par_flip);
      end
      send_bit(stop_v);
   endtask

   initial begin : watchdog
      #1_200_000;
      $display("FAIL watchdog: run exceeded time limit, pulses seen %0d", pulse_cnt);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int         p0;
      int         gap;
      logic [7:0] b;
      logic       bad_stop, flip;

      rst_n   = 1'b0;
      uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_rdata", rdata, 8'h00);
      check("reset_valid", rdata_valid, 1'b0);
      check("reset_ferr", framing_error, 1'b0);
      check("reset_perr", parity_error, 1'b0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // T1: single 0x55 and its latency
      lat_arm = 1'b1;
      send_frame(8'h55, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check($sformatf("t1_latency_%0d_within_1_of_%0d", lat_seen, EXP_LAT),
            int'(lat_seen >= EXP_LAT - 1 && lat_seen <= EXP_LAT + 1), 1);
      check("t1_queue_empty", exp_q.size(), 0);

      // T2: back-to-back frames, no idle gap
      p0 = pulse_cnt;
      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'hA3, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check("t2_pulses", pulse_cnt - p0, 3);
      check("t2_last_rdata", rdata, 8'hA3);

      // T3: 50-cycle glitch is rejected
      p0 = pulse_cnt;
      uart_rx = 1'b0;
      repeat (50) @(negedge clk);
      uart_rx = 1'b1;
      repeat (400) @(negedge clk);
      check("t3_no_pulse", pulse_cnt - p0, 0);

      // T4: stop bit low, long break, then a good frame
      p0 = pulse_cnt;
      send_frame(8'h00, 1'b0, 1'b0);
      repeat (3000) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      check("t4_one_ferr", pulse_cnt - p0, 1);
      send_frame(8'h3C, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check("t4_rdata", rdata, 8'h3C);
      check("t4_pulses", pulse_cnt - p0, 2);

      // T5: reset during data bit 4 of 0x96
      p0 = pulse_cnt;
      b  = 8'h96;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      uart_rx = b[4];
      repeat (CLKS / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_rst_rdata", rdata, 8'h00);
      check("t5_rst_valid", rdata_valid, 1'b0);
      last_good = 8'h00;
      uart_rx = 1'b1;
      rst_n   = 1'b1;
      repeat (3000) @(negedge clk);
      check("t5_no_pulse", pulse_cnt - p0, 0);
      send_frame(8'h42, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check("t5_rdata", rdata, 8'h42);

      // Randomized frames with occasional bad stop / parity bits and random gaps
      for (int n = 0; n < 10; n++) begin
         b        = 8'($urandom_range(0, 255));
         bad_stop = ($urandom_range(0, 3) == 0);
         flip     = PAR_EN && ($urandom_range(0, 3) == 0);
         send_frame(b, ~bad_stop, flip);
         uart_rx = 1'b1;
         gap = bad_stop ? int'($urandom_range(4, 40)) : int'($urandom_range(0, 40));
         repeat (gap) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("rand_queue_empty", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
      // T6: 0x07 with correct then wrong parity bit
      p0 = pulse_cnt;
      send_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      check("t6_pulses", pulse_cnt - p0, 2);
      check("t6_rdata", rdata, 8'h07);
`endif

      check("final_queue_empty", exp_q.size(), 0);
      check("final_rdata", rdata, last_good);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
